// File: rtl/apb_timer_param_if.sv
// APB slave bus bundle for apb_timer_param; data width follows the counter width.
interface apb_timer_param_if #(
   parameter int CNT_W = 8
);
   logic             psel;
   logic             penable;
   logic             pwrite;
   logic [7:0]       paddr;
   logic [CNT_W-1:0] pwdata;
   logic [CNT_W-1:0] prdata;
   logic             pready;
   logic             pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_timer_param.sv
// Parametrised APB timer: prescaled up/down counter with auto-reload,
// compare channel and maskable interrupt behind a zero-wait-state APB slave.
module apb_timer_param #(
   parameter int CNT_W = 8
) (
   input  logic             pclk,
   input  logic             presetn,
   apb_timer_param_if.slave apb,
   output logic             tmr_ovf,
   output logic             tmr_udf,
   output logic             tmr_cmp,
   output logic             tmr_irq
);

   localparam logic [7:0] ADDR_TDR  = 8'h00;
   localparam logic [7:0] ADDR_TCR  = 8'h01;
   localparam logic [7:0] ADDR_TSR  = 8'h02;
   localparam logic [7:0] ADDR_TCNT = 8'h03;
   localparam logic [7:0] ADDR_TCMP = 8'h04;
   localparam logic [7:0] ADDR_TIER = 8'h05;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] tdr_q, tdr_d;
   logic [CNT_W-1:0] tcnt_q, tcnt_d;
   logic [CNT_W-1:0] tcmp_q, tcmp_d;
   logic [7:0]       tcr_q, tcr_d;
   logic [7:0]       psc_q, psc_d;
   logic [2:0]       tsr_q, tsr_d;
   logic [2:0]       tier_q, tier_d;

   logic             ctlLoad;
   logic             ctlAutoReload;
   logic             ctlDown;
   logic             ctlEn;
   logic             ctlCmpEn;
   logic [2:0]       ctlCks;

   logic             wrEn;
   logic             rdEn;
   logic             addrHit;
   logic [CNT_W-1:0] rdMux;
   logic [7:0]       prescMask;
   logic             tick;
   logic             setOvf;
   logic             setUdf;
   logic             setCmp;

   assign ctlLoad       = tcr_q[7];
   assign ctlAutoReload = tcr_q[6];
   assign ctlDown       = tcr_q[5];
   assign ctlEn         = tcr_q[4];
   assign ctlCmpEn      = tcr_q[3];
   assign ctlCks        = tcr_q[2:0];

   assign wrEn = apb.psel & apb.penable & apb.pwrite;
   assign rdEn = apb.psel & ~apb.pwrite;

   // Software-visible configuration registers; TCNT and TSR are handled below.
   always_comb begin
      tdr_d  = tdr_q;
      tcr_d  = tcr_q;
      tcmp_d = tcmp_q;
      tier_d = tier_q;
      if (wrEn) begin
         case (apb.paddr)
            ADDR_TDR:  tdr_d  = apb.pwdata;
            ADDR_TCR:  tcr_d  = apb.pwdata[7:0];
            ADDR_TCMP: tcmp_d = apb.pwdata;
            ADDR_TIER: tier_d = apb.pwdata[2:0];
            default:   ;
         endcase
      end
   end

   // The prescaler low cks+1 bits all set marks the last cycle of a period.
   always_comb begin
      prescMask = 8'hFF >> (3'd7 - ctlCks);
      tick      = ctlEn & ~ctlLoad & ((psc_q & prescMask) == prescMask);
      if (!ctlEn || ctlLoad) begin
         psc_d = 8'h00;
      end else begin
         psc_d = psc_q + 8'd1;
      end
   end

   always_comb begin
      tcnt_d = tcnt_q;
      setOvf = 1'b0;
      setUdf = 1'b0;
      if (ctlLoad) begin
         tcnt_d = tdr_q;
      end else if (tick) begin
         if (!ctlDown) begin
            if (tcnt_q == CNT_MAX) begin
               setOvf = 1'b1;
               tcnt_d = ctlAutoReload ? tdr_q : '0;
            end else begin
               tcnt_d = tcnt_q + CNT_ONE;
            end
         end else begin
            if (tcnt_q == '0) begin
               setUdf = 1'b1;
               tcnt_d = ctlAutoReload ? tdr_q : CNT_MAX;
            end else begin
               tcnt_d = tcnt_q - CNT_ONE;
            end
         end
      end
      setCmp = tick & ctlCmpEn & (tcnt_d == tcmp_q);
   end

   // Hardware set is ORed in after the software clear, so a collision keeps the flag.
   always_comb begin
      tsr_d = tsr_q;
      if (wrEn && (apb.paddr == ADDR_TSR)) begin
         tsr_d = tsr_q & apb.pwdata[2:0];
      end
      tsr_d = tsr_d | {setCmp, setUdf, setOvf};
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         tdr_q  <= '0;
         tcr_q  <= 8'h00;
         tsr_q  <= 3'b000;
         tcnt_q <= '0;
         tcmp_q <= '0;
         tier_q <= 3'b000;
         psc_q  <= 8'h00;
      end else begin
         tdr_q  <= tdr_d;
         tcr_q  <= tcr_d;
         tsr_q  <= tsr_d;
         tcnt_q <= tcnt_d;
         tcmp_q <= tcmp_d;
         tier_q <= tier_d;
         psc_q  <= psc_d;
      end
   end

   always_comb begin
      rdMux   = '0;
      addrHit = 1'b1;
      case (apb.paddr)
         ADDR_TDR:  rdMux      = tdr_q;
         ADDR_TCR:  rdMux[7:0] = tcr_q;
         ADDR_TSR:  rdMux[2:0] = tsr_q;
         ADDR_TCNT: rdMux      = tcnt_q;
         ADDR_TCMP: rdMux      = tcmp_q;
         ADDR_TIER: rdMux[2:0] = tier_q;
         default:   addrHit    = 1'b0;
      endcase
   end

   assign apb.prdata  = rdEn ? rdMux : '0;
   assign apb.pready  = 1'b1;
   assign apb.pslverr = apb.psel & apb.penable & ~addrHit;

   assign tmr_ovf = tsr_q[0];
   assign tmr_udf = tsr_q[1];
   assign tmr_cmp = tsr_q[2];
   assign tmr_irq = |(tsr_q & tier_q);

endmodule
